// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus defines: LSU/MMU <-> dbus request/response structs and
// the dbus_arbiter FSM state encoding.
package dbus_arbiter_pkg;

  localparam int DBUS_AW = 32;
  localparam int DBUS_DW = 32;

  // Request issued by a bus master (LSU, page-table walker) or the arbiter.
  typedef struct packed {
    logic               ld_req;
    logic               st_req;
    logic [DBUS_AW-1:0] addr;
    logic [DBUS_DW-1:0] w_data;
    logic [1:0]         st_ops;   // store size: byte / half / word
  } type_lsu2dbus_s;

  // Response returned by the interconnect or the arbiter.
  typedef struct packed {
    logic [DBUS_DW-1:0] r_data;
    logic               ack;
  } type_dbus2lsu_s;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } type_dbus_arb_state_e;

  // A master is requesting when it asks for either a load or a store.
  function automatic logic is_req(input type_lsu2dbus_s r);
    return r.ld_req | r.st_req;
  endfunction

endpackage

// File: rtl/dbus_arbiter.sv
// Two-port round-robin arbiter in front of dbus_interconnect.
// Port 0 is the LSU, port 1 the page-table walker (MMU). One transaction is
// outstanding at a time; the winning request is registered and replayed
// downstream until the interconnect acks it.
// Optional feature: define DBUS_ARB_TIMEOUT_EN to abort a transaction that
// gets no ack within TMO_CYCLES busy cycles (forced ack, r_data=0, arb_err_o).
import dbus_arbiter_pkg::*;

module dbus_arbiter #(
  parameter int TMO_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  type_lsu2dbus_s lsu2arb_i,
  input  type_lsu2dbus_s mmu2arb_i,
  output type_dbus2lsu_s arb2lsu_o,
  output type_dbus2lsu_s arb2mmu_o,
  output type_lsu2dbus_s arb2dbus_o,
  input  type_dbus2lsu_s dbus2arb_i,
  output logic           arb_err_o
);

  // Reject a timeout window too short to ever abort anything.
  if (TMO_CYCLES < 1) begin : g_tmo_range
    $error("dbus_arbiter: TMO_CYCLES must be at least 1");
  end

  type_dbus_arb_state_e r_state;
  type_dbus_arb_state_e w_next_state;

  type_lsu2dbus_s r_req;         // request captured at grant time
  logic           r_grant;       // port owning the current transaction
  logic           r_last_grant;  // port served most recently

  logic           w_req0;
  logic           w_req1;
  logic           w_pick;        // winner if a grant happens this cycle
  logic           w_tmo;         // timeout abort this cycle
  logic           w_done;        // transaction ends this cycle
  type_dbus2lsu_s w_resp;

  assign w_req0 = is_req(lsu2arb_i);
  assign w_req1 = is_req(mmu2arb_i);

  // Round-robin pick: on contention the port not served last wins;
  // a lone requester always wins.
  assign w_pick = (w_req0 && w_req1) ? ~r_last_grant : w_req1;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;

  // Count busy cycles without ack; held at zero while idle so it starts
  // clean on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_tmo_cnt <= '0;
    end else if (!dbus2arb_i.ack) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_state == BUSY) && !dbus2arb_i.ack &&
                 (r_tmo_cnt == CNT_W'(TMO_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_done = (r_state == BUSY) && (dbus2arb_i.ack || w_tmo);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (latch).
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_req0 || w_req1) w_next_state = BUSY;
      BUSY: if (w_done)           w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
  end

  // Grant bookkeeping: capture the winner's request on grant, rotate
  // priority when its transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured request is reset too, so nothing stale can leak
    // downstream after a reset in the middle of a transaction.
    if (!rst_n) begin
      r_req        <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (r_state == IDLE) begin
      if (w_req0 || w_req1) begin
        r_grant <= w_pick;
        r_req   <= w_pick ? mmu2arb_i : lsu2arb_i;
      end
    end else if (w_done) begin
      r_last_grant <= r_grant;
      r_req        <= '0;
    end
  end

  // Outputs: drive downstream and route the response only while busy.
  always_comb begin
    arb2dbus_o = '0;
    arb2lsu_o  = '0;
    arb2mmu_o  = '0;
    arb_err_o  = 1'b0;
    w_resp     = '0;
    if (r_state == BUSY) begin
      arb2dbus_o    = r_req;
      w_resp.ack    = dbus2arb_i.ack | w_tmo;
      w_resp.r_data = w_tmo ? '0 : dbus2arb_i.r_data;
      arb_err_o     = w_tmo;
      if (r_grant) begin
        arb2mmu_o = w_resp;
      end else begin
        arb2lsu_o = w_resp;
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
import dbus_arbiter_pkg::*;

module tb_dbus_arbiter;

  logic           clk;
  logic           rst_n;
  type_lsu2dbus_s lsu;
  type_lsu2dbus_s mmu;
  type_dbus2lsu_s dn;
  type_dbus2lsu_s arb2lsu;
  type_dbus2lsu_s arb2mmu;
  type_lsu2dbus_s arb2dbus;
  logic           arb_err;

  int n_tests = 0;
  int n_fail  = 0;

  dbus_arbiter #(.TMO_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsu2arb_i  (lsu),
    .mmu2arb_i  (mmu),
    .arb2lsu_o  (arb2lsu),
    .arb2mmu_o  (arb2mmu),
    .arb2dbus_o (arb2dbus),
    .dbus2arb_i (dn),
    .arb_err_o  (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic type_lsu2dbus_s mk(input logic ld, input logic st,
                                        input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [1:0] ops);
    type_lsu2dbus_s r;
    r.ld_req = ld;
    r.st_req = st;
    r.addr   = a;
    r.w_data = d;
    r.st_ops = ops;
    return r;
  endfunction

  function automatic type_dbus2lsu_s rsp(input logic [31:0] d, input logic a);
    type_dbus2lsu_s r;
    r.r_data = d;
    r.ack    = a;
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_dbus"}, 128'(arb2dbus), 128'(type_lsu2dbus_s'('0)));
    check({tag, "_lsu"},  128'(arb2lsu),  128'(type_dbus2lsu_s'('0)));
    check({tag, "_mmu"},  128'(arb2mmu),  128'(type_dbus2lsu_s'('0)));
    check({tag, "_err"},  128'(arb_err),  128'(1'b0));
  endtask

  initial begin
    type_lsu2dbus_s l_ld, m_ld, l_st, m_ld2;
    l_ld  = mk(1'b1, 1'b0, 32'h8000_0010, 32'h0, 2'd0);
    m_ld  = mk(1'b1, 1'b0, 32'h8000_2000, 32'h0, 2'd0);
    l_st  = mk(1'b0, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 2'd2);
    m_ld2 = mk(1'b1, 1'b0, 32'h8000_3008, 32'h0, 2'd0);

    // Reset: outputs quiet while rst_n is low, across a clock edge.
    rst_n = 1'b0;
    lsu = '0; mmu = '0; dn = '0;
    @(negedge clk); #1;
    check_quiet("reset0");
    lsu = l_ld; mmu = m_ld; dn = rsp(32'h1, 1'b1);
    @(negedge clk); #1;
    check_quiet("reset_held");
    rst_n = 1'b1;

    // Contention right after reset: LSU, MMU, LSU with both held.
    #1;
    check("rr_idle_dbus", 128'(arb2dbus), 128'(type_lsu2dbus_s'('0)));
    check("rr_idle_ack",  128'(arb2lsu.ack), 128'(1'b0));
    dn = '0;
    @(negedge clk); #1;
    check("rr1_dbus", 128'(arb2dbus), 128'(l_ld));
    dn = rsp(32'h1111_1111, 1'b1); #1;
    check("rr1_lsu", 128'(arb2lsu), 128'(rsp(32'h1111_1111, 1'b1)));
    check("rr1_mmu", 128'(arb2mmu), 128'(type_dbus2lsu_s'('0)));
    @(negedge clk); dn = '0; #1;
    check("rr1_gap", 128'(arb2dbus), 128'(type_lsu2dbus_s'('0)));
    @(negedge clk); #1;
    check("rr2_dbus", 128'(arb2dbus), 128'(m_ld));
    dn = rsp(32'h2222_2222, 1'b1); #1;
    check("rr2_mmu", 128'(arb2mmu), 128'(rsp(32'h2222_2222, 1'b1)));
    check("rr2_lsu", 128'(arb2lsu), 128'(type_dbus2lsu_s'('0)));
    @(negedge clk); dn = '0; #1;
    check("rr2_gap", 128'(arb2dbus), 128'(type_lsu2dbus_s'('0)));
    @(negedge clk); #1;
    check("rr3_dbus", 128'(arb2dbus), 128'(l_ld));
    dn = rsp(32'h3333_3333, 1'b1); #1;
    check("rr3_lsu", 128'(arb2lsu), 128'(rsp(32'h3333_3333, 1'b1)));
    @(negedge clk); dn = '0; lsu = '0; mmu = '0;
    @(negedge clk);

    // Lone LSU load with 0xDEADBEEF reply.
    lsu = l_ld; #1;
    check("single_idle", 128'(arb2dbus), 128'(type_lsu2dbus_s'('0)));
    @(negedge clk); #1;
    check("single_dbus", 128'(arb2dbus), 128'(l_ld));
    check("single_noack", 128'(arb2lsu.ack), 128'(1'b0));
    dn = rsp(32'hDEAD_BEEF, 1'b1); #1;
    check("single_lsu", 128'(arb2lsu), 128'(rsp(32'hDEAD_BEEF, 1'b1)));
    check("single_mmu", 128'(arb2mmu), 128'(type_dbus2lsu_s'('0)));
    @(negedge clk); lsu = '0; dn = '0;

    // Spurious ack while idle is not forwarded.
    dn = rsp(32'h1234_5678, 1'b1); #1;
    check("spur_lsu", 128'(arb2lsu), 128'(type_dbus2lsu_s'('0)));
    check("spur_mmu", 128'(arb2mmu), 128'(type_dbus2lsu_s'('0)));
    @(negedge clk); dn = '0;

    // MMU arrives while the LSU store is in flight.
    lsu = l_st;
    @(negedge clk);
    mmu = m_ld2; #1;
    check("wait_dbus0", 128'(arb2dbus), 128'(l_st));
    check("wait_mmu0", 128'(arb2mmu), 128'(type_dbus2lsu_s'('0)));
    @(negedge clk); #1;
    check("wait_dbus1", 128'(arb2dbus), 128'(l_st));
    dn = rsp(32'h0, 1'b1); #1;
    check("wait_lsu_ack", 128'(arb2lsu.ack), 128'(1'b1));
    check("wait_mmu_ack", 128'(arb2mmu.ack), 128'(1'b0));
    @(negedge clk); lsu = '0; dn = '0; #1;
    check("wait_gap", 128'(arb2dbus), 128'(type_lsu2dbus_s'('0)));
    @(negedge clk); #1;
    check("wait_mmu_grant", 128'(arb2dbus), 128'(m_ld2));
    dn = rsp(32'h5555_AAAA, 1'b1); #1;
    check("wait_mmu_rsp", 128'(arb2mmu), 128'(rsp(32'h5555_AAAA, 1'b1)));
    @(negedge clk); mmu = '0; dn = '0;
    @(negedge clk);

    // Reset in the middle of a busy transaction.
    lsu = l_ld;
    @(negedge clk); #1;
    check("rstbusy_dbus", 128'(arb2dbus), 128'(l_ld));
    #2; rst_n = 1'b0; #1;
    check_quiet("rstbusy_low");
    dn = rsp(32'h9999_9999, 1'b1); #1;
    check_quiet("rstbusy_ack");
    @(negedge clk); rst_n = 1'b1; lsu = '0; #1;
    check_quiet("rstbusy_rel");
    @(negedge clk); dn = '0; #1;
    check_quiet("rstbusy_idle");

    // Store with no downstream ack: timeout after 4 busy cycles when built
    // with the abort, otherwise the transaction keeps waiting.
    lsu = l_st; dn = rsp(32'hFFFF_FFFF, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      check($sformatf("tmo_busy%0d_dbus", c), 128'(arb2dbus), 128'(l_st));
      check($sformatf("tmo_busy%0d_ack", c), 128'(arb2lsu.ack), 128'(1'b0));
      check($sformatf("tmo_busy%0d_err", c), 128'(arb_err), 128'(1'b0));
    end
    @(negedge clk); #1;
`ifdef DBUS_ARB_TIMEOUT_EN
    check("tmo_force_lsu", 128'(arb2lsu), 128'(rsp(32'h0, 1'b1)));
    check("tmo_force_err", 128'(arb_err), 128'(1'b1));
    check("tmo_force_mmu", 128'(arb2mmu), 128'(type_dbus2lsu_s'('0)));
    @(negedge clk); lsu = '0; dn = '0; #1;
    check_quiet("tmo_after");
`else
    check("notmo_ack", 128'(arb2lsu.ack), 128'(1'b0));
    check("notmo_err", 128'(arb_err), 128'(1'b0));
    @(negedge clk); lsu = '0; #1;
    check("notmo_still_busy", 128'(arb2dbus), 128'(l_st));
    dn = rsp(32'h7777_0000, 1'b1); #1;
    check("notmo_late_ack", 128'(arb2lsu), 128'(rsp(32'h7777_0000, 1'b1)));
    @(negedge clk); dn = '0; #1;
    check_quiet("notmo_after");
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 255: downstream cycles allowed before the timeout abort; only used when DBUS_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 lsu2arb_i  input  type_lsu2dbus_s  port 0 request (LSU): ld_req, st_req, addr, w_data, st_ops.
REQ-005 mmu2arb_i  input  type_lsu2dbus_s  port 1 request (page-table walker); load-only by convention, stores still honoured.
REQ-006 arb2lsu_o  output  type_dbus2lsu_s  port 0 response: r_data, ack.
REQ-007 arb2mmu_o  output  type_dbus2lsu_s  port 1 response: r_data, ack.
REQ-008 arb2dbus_o  output  type_lsu2dbus_s  request to dbus_interconnect.
REQ-009 dbus2arb_i  input  type_dbus2lsu_s  response from dbus_interconnect.
REQ-010 arb_err_o  output  1  one-cycle pulse on timeout abort; tied 0 without DBUS_ARB_TIMEOUT_EN.

Function
REQ-011 A port is requesting when its ld_req or st_req is 1; a requester SHALL hold its request stable until it sees its ack.
REQ-012 FSM states are IDLE and BUSY; the reset state is IDLE.
REQ-013 IDLE: if any port is requesting, the arbiter SHALL pick a winner, register its full request, and move to BUSY on the next edge.
REQ-014 Arbitration is round-robin: the last_grant flop resets to port 1, so port 0 wins the first contention; when both ports request, the port not in last_grant wins; a lone requester always wins.
REQ-015 BUSY: arb2dbus_o SHALL carry the registered request with ld_req/st_req asserted, starting one cycle after the request is sampled; in IDLE, arb2dbus_o SHALL be all zero.
REQ-016 BUSY: the combinational dbus2arb_i.ack and r_data SHALL go to the granted port in the same cycle; the other port's outputs SHALL stay zero.
REQ-017 When dbus2arb_i.ack=1 in BUSY, the arbiter SHALL update last_grant to the granted port and return to IDLE.
REQ-018 A new grant is possible in the cycle after an ack, so the minimum spacing is 2 cycles per transaction.
REQ-019 A new request arriving while BUSY SHALL wait; the registered request SHALL not change while BUSY.
REQ-020 Any dbus2arb_i.ack seen in IDLE SHALL be ignored and not forwarded to either port.

Reset
REQ-021 While rst_n=0, regardless of clk:
- state = IDLE, last_grant = 1, the registered request is zero, and the timeout counter is 0;
- all outputs are zero.
REQ-022 Reset during BUSY SHALL abandon the transaction with no ack to either port.

Configuration
REQ-023 Macro DBUS_ARB_TIMEOUT_EN, when defined, adds a counter with these rules:
- it clears on entry to BUSY and increments each BUSY cycle without ack;
- on the cycle where it equals TMO_CYCLES-1 with no ack, the arbiter SHALL send a forced ack with r_data=0 to the granted port, pulse arb_err_o, and return to IDLE.
REQ-024 Without the macro, there is no counter, BUSY persists until ack, and arb_err_o=0.

Structure
REQ-025 The typedefs type_lsu2dbus_s and type_dbus2lsu_s come from the shared defines package; a type_dbus_arb_state_e enum (IDLE, BUSY) SHALL be added to that package.
REQ-026 The block is a single module with no sub-modules; it is instantiated between the LSU/MMU and dbus_interconnect.

Verification
REQ-027 LSU ld_req with addr=0x8000_0010 alone -> arb2dbus_o.ld_req=1 one cycle later; a downstream ack with r_data=0xDEADBEEF gives arb2lsu_o.ack=1 and r_data=0xDEADBEEF in the same cycle, and arb2mmu_o stays 0.
REQ-028 Both ports request at the same cycle after reset -> LSU is served first, then MMU; with both held continuously, grants alternate LSU, MMU, LSU.
REQ-029 MMU request arrives while the LSU is BUSY -> arb2dbus_o stays on the LSU request until its ack, then the MMU is granted 2 cycles after the LSU ack edge.
REQ-030 rst_n driven low mid-BUSY -> all outputs are 0 immediately; after release, state is IDLE and no ack is delivered.
REQ-031 With DBUS_ARB_TIMEOUT_EN and TMO_CYCLES=4, a store with no downstream ack -> forced ack on the 4th BUSY cycle, arb_err_o pulses for 1 cycle, and the arbiter returns to IDLE.
REQ-032 A spurious dbus2arb_i.ack in IDLE -> both port acks stay 0.
